// File: rtl/test_pkg_a.sv
// Hero-bus beat definitions shared by producers and collectors.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package test_pkg_a;

  localparam int HERO_WIDTH = 8;

  // Beat framing: VALID carries payload, DONE closes a transaction,
  // IDLE between transactions (or an abort when seen mid-transaction).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    DONE  = 2'd2
  } CYCLE_TYPE_E;

  typedef struct packed {
    logic [1:0] mask;
    logic       posted;
  } hero_write_t;

endpackage

// File: rtl/test_pkg_b.sv
// Inter-package record produced by the hero record collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package test_pkg_b;

  localparam int NEW_PARAM       = 5;
  localparam int COLLECTOR_DEPTH = 4;

  typedef enum logic {
    COL_IDLE  = 1'b0,
    COL_ACCUM = 1'b1
  } COLLECTOR_STATE_E;

  typedef struct packed {
    logic [test_pkg_a::HERO_WIDTH-1:0] fielda;  // first beat data
    test_pkg_a::hero_write_t           fieldb;  // first beat write attrs
    test_pkg_a::CYCLE_TYPE_E           fieldc;  // closing beat type
    logic [NEW_PARAM-1:0]              fieldd;  // saturating beat count
  } another_struct_t;

endpackage

// File: rtl/hero_record_fifo.sv
// Synchronous FIFO of another_struct_t with a registered head output.
// Latency: push at N is visible at the head at N+1 when empty.
// Backpressure: caller must not push when full; pop only when !empty.
// Ports: clk/rst, push/din, pop, dout (head), full, empty, level.
module hero_record_fifo
  import test_pkg_b::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  another_struct_t          din,
  input  logic                     pop,
  output another_struct_t          dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  another_struct_t mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_ptr_nxt;
  logic [LW-1:0]   level_nxt;

  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  assign rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
  assign level_nxt  = level + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      // Reload the head register whenever the head moves or the FIFO fills
      // from empty; a push landing on the new head slot forwards din since
      // mem has not been written yet.
      if ((pop || empty) && (level_nxt != '0)) begin
        if (push && (wr_ptr == rd_ptr_nxt)) begin
          dout <= din;
        end else begin
          dout <= mem[rd_ptr_nxt];
        end
      end
    end
  end

endmodule

// File: rtl/hero_record_collector.sv
// Collects framed hero-bus beats into one another_struct_t record per transaction.
// Latency: closing beat accepted at N gives rec_vld at N+1 (FIFO empty).
// Backpressure: hero_ready drops while the record FIFO is full; no bypass.
// Ports: clk/rst, hero_cycle/hero_data/hero_write/hero_ready beat input,
//        rec_vld/rec_rdy/rec record output, fifo_level occupancy.
module hero_record_collector
  import test_pkg_a::*;
  import test_pkg_b::*;
#(
  parameter int DEPTH = COLLECTOR_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  CYCLE_TYPE_E            hero_cycle,
  input  logic [HERO_WIDTH-1:0]  hero_data,
  input  hero_write_t            hero_write,
  output logic                   hero_ready,
  output logic                   rec_vld,
  input  logic                   rec_rdy,
  output another_struct_t        rec,
  output logic [$clog2(DEPTH):0] fifo_level
);

  COLLECTOR_STATE_E        state;
  logic [NEW_PARAM-1:0]    count;
  logic [HERO_WIDTH-1:0]   first_data;
  hero_write_t             first_write;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  another_struct_t         push_rec;

  assign hero_ready = !fifo_full;
  assign rec_vld    = !fifo_empty;
  assign pop        = rec_vld && rec_rdy;

  // Record pushed on the accept cycle of the closing beat.
  always_comb begin
    push     = 1'b0;
    push_rec = '0;
    if (hero_ready) begin
      case (state)
        COL_IDLE: begin
          if (hero_cycle == DONE) begin
            push            = 1'b1;
            push_rec.fieldc = DONE;
          end
        end
        COL_ACCUM: begin
          if (hero_cycle == DONE || hero_cycle == IDLE) begin
            push            = 1'b1;
            push_rec.fielda = first_data;
            push_rec.fieldb = first_write;
            push_rec.fieldc = hero_cycle;
            push_rec.fieldd = count;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COL_IDLE;
      count       <= '0;
      first_data  <= '0;
      first_write <= '0;
    end else if (hero_ready) begin
      case (state)
        COL_IDLE: begin
          if (hero_cycle == VALID) begin
            first_data  <= hero_data;
            first_write <= hero_write;
            count       <= NEW_PARAM'(1);
            state       <= COL_ACCUM;
          end
        end
        COL_ACCUM: begin
          if (hero_cycle == VALID) begin
            if (count != '1) begin
              count <= count + 1'b1;
            end
          end else if (hero_cycle == DONE || hero_cycle == IDLE) begin
            state <= COL_IDLE;
          end
        end
        default: state <= COL_IDLE;
      endcase
    end
  end

  hero_record_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_rec),
    .pop   (pop),
    .dout  (rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_hero_record_collector.sv
// Scoreboard bench for hero_record_collector.
// Latency: n/a.
// Backpressure: exercised via rec_rdy.
module tb_hero_record_collector;
  import test_pkg_a::*;
  import test_pkg_b::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  CYCLE_TYPE_E           hero_cycle = IDLE;
  logic [HERO_WIDTH-1:0] hero_data  = '0;
  hero_write_t           hero_write = '0;
  logic                  hero_ready;
  logic                  rec_vld;
  logic                  rec_rdy = 1'b1;
  another_struct_t       rec;
  logic [LW-1:0]         fifo_level;

  int pass_cnt  = 0;
  int total_cnt = 0;
  another_struct_t exp_q[$];

  hero_write_t w1 = '{mask: 2'b01, posted: 1'b1};
  hero_write_t w2 = '{mask: 2'b10, posted: 1'b0};
  hero_write_t w3 = '{mask: 2'b11, posted: 1'b1};
  hero_write_t wz = '0;

  always #5 clk = ~clk;

  hero_record_collector #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .hero_cycle (hero_cycle),
    .hero_data  (hero_data),
    .hero_write (hero_write),
    .hero_ready (hero_ready),
    .rec_vld    (rec_vld),
    .rec_rdy    (rec_rdy),
    .rec        (rec),
    .fifo_level (fifo_level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic another_struct_t mk(input logic [HERO_WIDTH-1:0] d, input hero_write_t w,
                                         input CYCLE_TYPE_E c, input logic [NEW_PARAM-1:0] n);
    another_struct_t r;
    r.fielda = d;
    r.fieldb = w;
    r.fieldc = c;
    r.fieldd = n;
    return r;
  endfunction

  // Monitor: every handshake pops one expected record.
  always @(negedge clk) begin
    if (!rst && rec_vld && rec_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 64'(rec), 64'hDEAD);
      end else begin
        check("record", 64'(rec), 64'(exp_q.pop_front()));
      end
    end
  end

  // Present a beat from posedge+1 and wait (bounded) until it is accepted.
  task automatic send(input CYCLE_TYPE_E c, input logic [HERO_WIDTH-1:0] d, input hero_write_t w);
    bit acc;
    hero_cycle = c;
    hero_data  = d;
    hero_write = w;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      acc = hero_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_hero_ready", 64'(hero_ready), 64'(1));
    check("reset_rec_vld",    64'(rec_vld),    64'(0));
    check("reset_level",      64'(fifo_level), 64'(0));
    check("reset_rec",        64'(rec),        64'(0));

    // Lone DONE
    exp_q.push_back(mk('0, wz, DONE, 5'd0));
    send(DONE, 8'h77, w3);
    hero_cycle = IDLE;
    check("done_rec_vld", 64'(rec_vld), 64'(1));
    step();

    // Three VALIDs then DONE
    exp_q.push_back(mk(8'h0A, w1, DONE, 5'd3));
    send(VALID, 8'h0A, w1);
    send(VALID, 8'h0B, w2);
    send(VALID, 8'h0C, w3);
    check("accum_no_vld", 64'(rec_vld), 64'(0));
    send(DONE, 8'h00, wz);
    hero_cycle = IDLE;
    check("accum_rec_vld", 64'(rec_vld), 64'(1));
    step();

    // Saturation: 40 VALIDs
    exp_q.push_back(mk(8'h10, w2, DONE, 5'd31));
    for (int i = 0; i < 40; i++) send(VALID, HERO_WIDTH'(8'h10 + i), (i == 0) ? w2 : w3);
    send(DONE, 8'h00, wz);
    hero_cycle = IDLE;
    step();

    // Abort, then further IDLE produces nothing
    exp_q.push_back(mk(8'h21, w1, IDLE, 5'd2));
    send(VALID, 8'h21, w1);
    send(VALID, 8'h22, w2);
    send(IDLE, 8'h00, wz);
    check("abort_rec_vld", 64'(rec_vld), 64'(1));
    repeat (4) step();
    check("abort_idle_level", 64'(fifo_level), 64'(0));
    check("abort_idle_vld",   64'(rec_vld),    64'(0));

    // Full FIFO backpressure
    rec_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(mk(HERO_WIDTH'(i), w1, DONE, 5'd1));
      send(VALID, HERO_WIDTH'(i), w1);
      send(DONE, 8'h00, wz);
    end
    check("full_level", 64'(fifo_level), 64'(4));
    check("full_ready", 64'(hero_ready), 64'(0));
    exp_q.push_back(mk('0, wz, DONE, 5'd0));
    hero_cycle = DONE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_held_ready", 64'(hero_ready), 64'(0));
      step();
    end
    check("full_held_level", 64'(fifo_level), 64'(4));
    rec_rdy = 1'b1;
    step();
    rec_rdy = 1'b0;
    check("reopen_ready", 64'(hero_ready), 64'(1));
    check("reopen_level", 64'(fifo_level), 64'(3));
    step();
    hero_cycle = IDLE;
    check("fifth_level", 64'(fifo_level), 64'(4));
    rec_rdy = 1'b1;
    repeat (6) step();
    check("drain_level", 64'(fifo_level), 64'(0));

    // Reset mid-transaction
    send(VALID, 8'h31, w1);
    send(VALID, 8'h32, w2);
    hero_cycle = IDLE;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_level", 64'(fifo_level), 64'(0));
    check("midrst_vld",   64'(rec_vld),    64'(0));
    step();
    check("midrst_idle_vld", 64'(rec_vld), 64'(0));
    exp_q.push_back(mk(8'h05, w3, DONE, 5'd1));
    send(VALID, 8'h05, w3);
    send(DONE, 8'h00, wz);
    hero_cycle = IDLE;

    for (int t = 0; t < 50 && (exp_q.size() != 0 || fifo_level != '0); t++) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    check("final_level",      64'(fifo_level),   64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/hero_record_collector.md
# hero_record_collector

Collects hero-bus beats, framed by `test_pkg_a::CYCLE_TYPE_E` (IDLE/VALID/DONE), into one `test_pkg_b::another_struct_t` record per transaction. Completed records go through a small record FIFO to a valid/ready consumer. The block sits directly upstream of every consumer of `another_struct_t`. It is the producer side of the inter-package record defined in `test_pkg_b`.

## Interface
- `DEPTH`, 4: record FIFO entries; power of two, ≥2.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `hero_cycle` in `test_pkg_a::CYCLE_TYPE_E`: beat type, sampled when `hero_ready`=1.
- `hero_data` in `test_pkg_a::HERO_WIDTH`: beat payload, meaningful on VALID only.
- `hero_write` in `test_pkg_a::hero_write_t`: beat write attributes, meaningful on VALID only.
- `hero_ready` out 1: beat accepted this cycle; equals `!fifo_full`, combinational from registered state only.
- `rec_vld` out 1: FIFO head valid.
- `rec_rdy` in 1: consumer accepts head.
- `rec` out `test_pkg_b::another_struct_t`: FIFO head record.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- FSM states `COL_IDLE`, `COL_ACCUM`. Beats are consumed only when `hero_ready`=1. When `hero_ready`=0, inputs are ignored and no state changes.
- COL_IDLE:
  - IDLE beat: stay.
  - VALID beat: capture `fielda`=`hero_data` and `fieldb`=`hero_write`, set count=1, go to ACCUM.
  - DONE beat: push a zero-beat record (`fielda`='0, `fieldb`='0, `fieldc`=DONE, `fieldd`=0), stay.
- COL_ACCUM:
  - VALID beat: count increments and saturates at 2^NEW_PARAM−1 (31). `fielda`/`fieldb` keep first-beat values.
  - DONE beat: push {first data, first write, DONE, count}, go to IDLE.
  - IDLE beat (abort): push {first data, first write, IDLE, count}, go to IDLE.
- `fieldd` is `NEW_PARAM` bits wide. Count arithmetic is unsigned and saturating, never wrapping.
- FIFO behaviour:
  - Push happens on the accept cycle of the closing beat.
  - Pop happens when `rec_vld && rec_rdy`.
  - Push and pop in the same cycle: occupancy unchanged.
  - Full: `hero_ready`=0, including for IDLE/VALID beats. There is no bypass, so a same-cycle pop does not reopen `hero_ready` until the next cycle.
  - Empty: `rec_vld`=0. `rec` holds its last value and is don't-care.
- Reset values: state=COL_IDLE, count=0, FIFO empty, `rec_vld`=0, `fifo_level`=0, `hero_ready`=1 in the first cycle after reset deasserts. `rec` resets to '0.
- Reset mid-transaction discards the partial record. No record is emitted.

## Timing
- Closing beat accepted at cycle N → `rec_vld`=1 at N+1 if the FIFO was empty.
- Pop at cycle N → `fifo_level` decrements at N+1, and the next entry appears on `rec` at N+1.
- Full at N → `hero_ready`=0 at N. A pop at N → `hero_ready`=1 at N+1.
- Throughput: one beat per cycle while not full. Back-to-back DONE beats yield one record per cycle.
- `rec`/`rec_vld` are driven straight from FIFO registers. There is no combinational path from `rec_rdy` to `rec_vld`.

## Structure
- In `test_pkg_b` (YIS-generated):
  - enum `COLLECTOR_STATE_E` {COL_IDLE, COL_ACCUM}.
  - localparam `COLLECTOR_DEPTH`=4.
  - `another_struct_t` as existing.
- Widths come only from `test_pkg_a::HERO_WIDTH` and `test_pkg_b::NEW_PARAM`; none are hard-coded.
- One sub-module, `hero_record_fifo`: a parameterized synchronous FIFO of `another_struct_t` with push/pop/full/empty/level, registered outputs, and the same `clk`/`rst`.

## Test plan
- Reset, then DONE→IDLE: after reset `hero_ready`=1, `rec_vld`=0, `fifo_level`=0. A lone DONE yields `rec`={0,0,DONE,0} one cycle later.
- VALID(data=0xA, write=W1), VALID(0xB,W2), VALID(0xC,W3), DONE → one record {0xA, W1, DONE, 3}; `rec_vld` rises the cycle after DONE.
- 40 VALID beats then DONE → `fieldd`=31 (saturated), `fielda` = first beat's data.
- VALID, VALID, then IDLE → abort record {first data, first write, IDLE, 2}. A following IDLE beat produces nothing.
- `rec_rdy`=0 with 4 DONE beats → `fifo_level`=4 and `hero_ready`=0; a 5th DONE held for 3 cycles is not accepted. Raise `rec_rdy` for one cycle → `hero_ready`=1 next cycle, the 5th record is accepted, and records drain in order.
- Assert `rst` for one cycle after VALID, VALID → no record emitted. A subsequent VALID(0x5), DONE yields {0x5, W, DONE, 1}.
